calc_ctrl_seq: RTL and testbench

//  Parametrised successor FSM sequencer for the small calculator datapath (MUX1 -> regfile -> ALU -> MUX2).

---
 rtl/calc_ctrl_seq_pkg.sv | 30 +++
 rtl/calc_ctrl_seq_op_decode.sv | 15 +
 rtl/calc_ctrl_seq.sv | 175 +++++++++++++++++
 tb/tb_calc_ctrl_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/calc_ctrl_seq_pkg.sv
// Shared definitions for the calculator control sequencer: state encodings,
// opcode values and the legal-opcode check.
package calc_ctrl_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE1 = 3'd1,
        ST_WRITE2 = 3'd2,
        ST_READ   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WB     = 3'd5,
        ST_OUTPUT = 3'd6,
        ST_HOLD   = 3'd7
    } state_t;

    localparam int OP_XOR    = 0;
    localparam int OP_AND    = 1;
    localparam int OP_SUB    = 2;
    localparam int OP_ADD    = 3;
    localparam int OP_OR     = 4;
    localparam int OP_PASS_A = 5;

    // Wide enough for the largest supported ALU latency (15).
    localparam int CNT_W = 4;

    function automatic logic op_legal(input logic [31:0] code);
        return code <= 32'(OP_PASS_A);
    endfunction

endpackage

// File: rtl/calc_ctrl_seq_op_decode.sv
// Combinational opcode decode: ALU control word plus legality flag.
module calc_op_decode
    import calc_ctrl_seq_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic [OP_W-1:0] op,
    output logic [OP_W-1:0] c,
    output logic            legal
);

    assign c     = op;
    assign legal = op_legal(32'(op));

endmodule

// File: rtl/calc_ctrl_seq.sv
// Sequencer for the MUX1 -> regfile -> ALU -> MUX2 calculator datapath with
// go/done handshake, chain mode, configurable ALU latency and illegal-op flag.
module calc_ctrl_seq
    import calc_ctrl_seq_pkg::*;
#(
    parameter int ADDR_W  = 2,
    parameter int OP_W    = 3,
    parameter int ALU_LAT = 1,
    parameter int SRC_A   = 1,
    parameter int SRC_B   = 2,
    parameter int RES     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              chain,
    input  logic [OP_W-1:0]   op,
    output logic [1:0]        s1,
    output logic [ADDR_W-1:0] WA,
    output logic              WE,
    output logic [ADDR_W-1:0] RAA,
    output logic [ADDR_W-1:0] RAB,
    output logic              REA,
    output logic              REB,
    output logic [OP_W-1:0]   C,
    output logic              S2,
    output logic [2:0]        cs,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state, state_nxt;
    logic [OP_W-1:0]   op_q, op_nxt;
    logic              chain_q, chain_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [OP_W-1:0]   c_nxt;
    logic              legal_nxt;

    logic [1:0]        s1_n;
    logic [ADDR_W-1:0] wa_n, raa_n, rab_n, raa_rd;
    logic              we_n, rea_n, reb_n, s2_n, done_n, err_n, busy_n;
    logic [OP_W-1:0]   c_n;

    calc_op_decode #(.OP_W(OP_W)) u_dec (
        .op    (op_nxt),
        .c     (c_nxt),
        .legal (legal_nxt)
    );

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        chain_nxt = chain_q;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    op_nxt    = op;
                    chain_nxt = chain;
                    state_nxt = chain ? ST_WRITE2 : ST_WRITE1;
                end
            end
            ST_WRITE1: state_nxt = ST_WRITE2;
            ST_WRITE2: state_nxt = ST_READ;
            ST_READ: begin
                state_nxt = ST_EXEC;
                cnt_nxt   = CNT_W'(ALU_LAT - 1);
            end
            ST_EXEC: begin
                if (cnt == '0) state_nxt = ST_WB;
                else           cnt_nxt   = cnt - 1'b1;
            end
            ST_WB:     state_nxt = ST_OUTPUT;
            ST_OUTPUT: state_nxt = go ? ST_HOLD : ST_IDLE;
            ST_HOLD:   if (!go) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies stay
    // aligned with cs while still resetting asynchronously to zero.
    always_comb begin
        s1_n   = '0;
        wa_n   = '0;
        we_n   = 1'b0;
        raa_n  = '0;
        rab_n  = '0;
        rea_n  = 1'b0;
        reb_n  = 1'b0;
        c_n    = '0;
        s2_n   = 1'b0;
        done_n = 1'b0;
        err_n  = 1'b0;
        busy_n = (state_nxt != ST_IDLE);
        raa_rd = chain_nxt ? ADDR_W'(RES) : ADDR_W'(SRC_A);
        case (state_nxt)
            ST_WRITE1: begin
                s1_n = 2'd3;
                wa_n = ADDR_W'(SRC_A);
                we_n = 1'b1;
            end
            ST_WRITE2: begin
                s1_n = 2'd2;
                wa_n = ADDR_W'(SRC_B);
                we_n = 1'b1;
            end
            ST_READ, ST_EXEC: begin
                raa_n = raa_rd;
                rab_n = ADDR_W'(SRC_B);
                rea_n = 1'b1;
                reb_n = 1'b1;
                c_n   = c_nxt;
            end
            ST_WB: begin
                wa_n  = ADDR_W'(RES);
                we_n  = legal_nxt;
                raa_n = raa_rd;
                rab_n = ADDR_W'(SRC_B);
                rea_n = 1'b1;
                reb_n = 1'b1;
                c_n   = c_nxt;
            end
            ST_OUTPUT, ST_HOLD: begin
                raa_n  = ADDR_W'(RES);
                rea_n  = 1'b1;
                s2_n   = 1'b1;
                done_n = 1'b1;
                err_n  = !legal_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            chain_q <= 1'b0;
            cnt     <= '0;
            s1      <= '0;
            WA      <= '0;
            WE      <= 1'b0;
            RAA     <= '0;
            RAB     <= '0;
            REA     <= 1'b0;
            REB     <= 1'b0;
            C       <= '0;
            S2      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            op_q    <= op_nxt;
            chain_q <= chain_nxt;
            cnt     <= cnt_nxt;
            s1      <= s1_n;
            WA      <= wa_n;
            WE      <= we_n;
            RAA     <= raa_n;
            RAB     <= rab_n;
            REA     <= rea_n;
            REB     <= reb_n;
            C       <= c_n;
            S2      <= s2_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
        end
    end

    assign cs = state;

endmodule

// File: tb/tb_calc_ctrl_seq.sv
// Bench for calc_ctrl_seq: two instances (ALU_LAT 1 and 3) share stimulus;
// expected per-cycle output vectors are queued at each start and popped per edge.
module tb_calc_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0;
    logic       chain = 1'b0;
    logic [2:0] op = 3'd0;

    logic [1:0] s1_a, s1_b;
    logic [1:0] wa_a, wa_b, raa_a, raa_b, rab_a, rab_b;
    logic       we_a, we_b, rea_a, rea_b, reb_a, reb_b;
    logic [2:0] c_a, c_b, cs_a, cs_b;
    logic       s2_a, s2_b, busy_a, busy_b, done_a, done_b, err_a, err_b;

    typedef logic [20:0] vec_t;
    vec_t q1[$];
    vec_t q3[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    calc_ctrl_seq #(.ALU_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .go(go), .chain(chain), .op(op),
        .s1(s1_a), .WA(wa_a), .WE(we_a), .RAA(raa_a), .RAB(rab_a),
        .REA(rea_a), .REB(reb_a), .C(c_a), .S2(s2_a), .cs(cs_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    calc_ctrl_seq #(.ALU_LAT(3)) u_l3 (
        .clk(clk), .rst(rst), .go(go), .chain(chain), .op(op),
        .s1(s1_b), .WA(wa_b), .WE(we_b), .RAA(raa_b), .RAB(rab_b),
        .REA(rea_b), .REB(reb_b), .C(c_b), .S2(s2_b), .cs(cs_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    wire vec_t obs1 = {cs_a, s1_a, wa_a, we_a, raa_a, rab_a, rea_a, reb_a,
                       c_a, s2_a, busy_a, done_a, err_a};
    wire vec_t obs3 = {cs_b, s1_b, wa_b, we_b, raa_b, rab_b, rea_b, reb_b,
                       c_b, s2_b, busy_b, done_b, err_b};

    // Output table per state, straight from the behaviour description.
    function automatic vec_t exp_vec(input int st, input int opv, input bit ch);
        logic [2:0] cs_e = 3'(st);
        logic [1:0] s1_e = 2'd0, wa_e = 2'd0, raa_e = 2'd0, rab_e = 2'd0;
        logic       we_e = 1'b0, rea_e = 1'b0, reb_e = 1'b0;
        logic [2:0] c_e = 3'd0;
        logic       s2_e = 1'b0, done_e = 1'b0, err_e = 1'b0;
        logic       busy_e = (st != 0);
        logic       lgl = (opv <= 5);
        logic [1:0] rd_a = ch ? 2'd3 : 2'd1;
        case (st)
            1: begin s1_e = 2'd3; wa_e = 2'd1; we_e = 1'b1; end
            2: begin s1_e = 2'd2; wa_e = 2'd2; we_e = 1'b1; end
            3, 4: begin
                raa_e = rd_a; rab_e = 2'd2; rea_e = 1'b1; reb_e = 1'b1; c_e = 3'(opv);
            end
            5: begin
                wa_e = 2'd3; we_e = lgl; raa_e = rd_a; rab_e = 2'd2;
                rea_e = 1'b1; reb_e = 1'b1; c_e = 3'(opv);
            end
            6, 7: begin
                raa_e = 2'd3; rea_e = 1'b1; s2_e = 1'b1; done_e = 1'b1; err_e = !lgl;
            end
            default: ;
        endcase
        return {cs_e, s1_e, wa_e, we_e, raa_e, rab_e, rea_e, reb_e,
                c_e, s2_e, busy_e, done_e, err_e};
    endfunction

    function automatic void add(input bit to3, input vec_t v);
        if (to3) q3.push_back(v);
        else     q1.push_back(v);
    endfunction

    // Expected states after edges 1..n of a start (edge 1 samples go=1),
    // followed by HOLD while go is still sampled high (go held for g edges).
    function automatic void push_seq(input bit to3, input int lat, input int opv,
                                     input bit ch, input int g);
        int n = (ch ? 4 : 5) + lat;
        if (!ch) add(to3, exp_vec(1, opv, ch));
        add(to3, exp_vec(2, opv, ch));
        add(to3, exp_vec(3, opv, ch));
        for (int i = 0; i < lat; i++) add(to3, exp_vec(4, opv, ch));
        add(to3, exp_vec(5, opv, ch));
        add(to3, exp_vec(6, opv, ch));
        if (g >= n + 1)
            for (int i = 0; i < g - n; i++) add(to3, exp_vec(7, opv, ch));
    endfunction

    task automatic check(input string tag, input vec_t obs, input vec_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        vec_t e1, e3;
        @(posedge clk);
        #1;
        e1 = (q1.size() != 0) ? q1.pop_front() : exp_vec(0, 0, 1'b0);
        e3 = (q3.size() != 0) ? q3.pop_front() : exp_vec(0, 0, 1'b0);
        check("lat1", obs1, e1);
        check("lat3", obs3, e3);
    endtask

    task automatic run_op(input int opv, input bit ch, input int g);
        int k = 0;
        go    = 1'b1;
        op    = 3'(opv);
        chain = ch;
        push_seq(1'b0, 1, opv, ch, g);
        push_seq(1'b1, 3, opv, ch, g);
        while ((q1.size() != 0 || q3.size() != 0) && k < 300) begin
            step();
            k++;
            go    = (k < g);
            op    = 3'($urandom);
            chain = 1'($urandom);
        end
        tests++;
        assert (q1.size() == 0 && q3.size() == 0) else begin
            fails++;
            $error("FAIL timeout observed=%0d expected=0", q1.size() + q3.size());
        end
        go = 1'b0;
        step();
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", obs1, exp_vec(0, 0, 1'b0));
        check("reset", obs3, exp_vec(0, 0, 1'b0));
        rst = 1'b1;
        step();

        run_op(3, 1'b0, 1);     // ADD
        run_op(2, 1'b0, 1);     // SUB
        run_op(0, 1'b1, 1);     // chained XOR
        run_op(7, 1'b0, 1);     // illegal
        run_op(6, 1'b1, 1);     // illegal, chained
        run_op(5, 1'b0, 1);     // legal again clears err
        run_op(4, 1'b0, 19);    // go held: HOLD for many cycles
        run_op(1, 1'b1, 2);

        // Reset asserted mid-EXEC, between clock edges.
        go = 1'b1; op = 3'd3; chain = 1'b0;
        push_seq(1'b0, 1, 3, 1'b0, 1);
        push_seq(1'b1, 3, 3, 1'b0, 1);
        step();
        go = 1'b0;
        repeat (3) step();
        #2 rst = 1'b0;
        #1;
        check("rst_mid_exec", obs1, exp_vec(0, 0, 1'b0));
        check("rst_mid_exec", obs3, exp_vec(0, 0, 1'b0));
        q1.delete();
        q3.delete();
        #1 rst = 1'b1;
        op = 3'd6; chain = 1'b1;
        repeat (3) step();
        op = 3'd2;
        step();
        run_op(1, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
